misr_signature_analyzer: RTL and testbench
==========================================

Name: misr_signature_analyzer

Overview:
- BIST response compactor. It sits at the output end of the test path, opposite the LFSR pattern generator.
- It absorbs one WIDTH-bit circuit-under-test response per valid cycle into a Multiple-Input Signature Register (MISR), using a programmable polynomial and seed.
- After a programmed number of responses it freezes the signature, compares it against a golden value and reports done/pass.

Parameters:
WIDTH, 8, width of signature, poly, seed, golden and response data
COUNT_W, 8, width of the pattern counter and num_patterns

Ports:
clock  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset; 0 = reset
en  input  1  global enable; 0 freezes all state, including the FSM and counter
start  input  1  begin a new compaction session (sampled in IDLE or DONE only)
poly  input  WIDTH  feedback polynomial, latched on start
seed  input  WIDTH  initial signature, loaded on start
golden  input  WIDTH  expected signature, latched on start
num_patterns  input  COUNT_W  number of responses to compact, latched on start
data_in  input  WIDTH  CUT response word
data_valid  input  1  data_in is valid this cycle
signature  output  WIDTH  current MISR contents
busy  output  1  high in COMPACT
done  output  1  high in DONE
pass  output  1  valid when done=1: final signature == golden

Behaviour:
- Reset (rst=0, asynchronous): signature=0, busy=0, done=0, pass=0, counter=0, latched poly/golden/num=0, state=IDLE.
- All state changes happen on the rising clock edge and only when en=1. When en=0, everything holds.
- FSM states: IDLE, COMPACT, DONE.
- IDLE or DONE, with start=1:
  - signature<=seed; latch poly, golden and num_patterns; counter<=0; done<=0; pass<=0.
  - If num_patterns==0: go to DONE; done<=1; pass<=(seed==golden).
  - Otherwise: go to COMPACT; busy<=1.
- COMPACT, with data_valid=1 (sample accepted):
  - signature <= {signature[WIDTH-2:0],1'b0} ^ (signature[WIDTH-1] ? poly_l : 0) ^ data_in. This is the Galois form, shifting left.
  - counter<=counter+1.
  - If counter==num_l-1: go to DONE; busy<=0; done<=1; pass<=(next_signature==golden_l). The comparison uses the updated value within the same edge.
- COMPACT, with data_valid=0: hold.
- start is ignored in COMPACT. A session cannot be aborted except by reset.
- Latency:
  - The earliest first sample is the cycle after start is accepted.
  - done/pass are visible the cycle after the last sample's edge.
  - Total run is num_patterns+1 edges minimum.
- DONE: signature, done and pass hold until the next start or reset.
- start in the same cycle as en=0: ignored.
- poly/golden/num_patterns/seed changes after start: no effect on the current session.
- Reset mid-COMPACT: immediate return to the reset values. The partial signature is lost.
- Counter: wraps never. Maximum session length is 2^COUNT_W-1 patterns.

Optional Feature:
- Macro: MISR_XMASK_EN.
- Defined: adds input port xmask [WIDTH]. The compacted word is data_in & ~xmask, so unknown (X) response bits are blocked from corrupting the signature.
- Undefined: no xmask port; data_in is compacted unmodified.

Test Plan:
- Basic compaction, pass: WIDTH=8, poly=8'h1D, seed=8'h00, golden=8'h00, num=2, data 8'h01 then 8'h02 -> signature 8'h01 after the 1st sample, 8'h00 after the 2nd; done=1, pass=1, busy=0.
- Feedback and fail: seed=8'h80, poly=8'h1D, num=1, data 8'h00 -> signature 8'h1D. With golden=8'h1D, pass=1. Rerun with golden=8'h1C -> done=1, pass=0.
- Zero patterns: seed=8'hA5, golden=8'hA5, num=0, start -> next cycle done=1, pass=1, busy never asserted.
- Stall and freeze: the first scenario with data_valid=0 for 2 cycles and en=0 for 3 cycles between samples, plus start pulses during COMPACT -> same final 8'h00/pass=1; signature and counter constant during the stalls; start ignored.
- Reset mid-run: assert rst=0 asynchronously after 1 accepted sample -> signature=0, busy=0, done=0 immediately. A new start then completes normally.
- (MISR_XMASK_EN) xmask=8'hFF, seed=8'h80, poly=8'h1D, num=1, data=8'h5A -> signature 8'h1D, same as data 8'h00.

Source files
------------

// File: rtl/misr_signature_analyzer_if.sv
// Bus bundle for misr_signature_analyzer: session setup, response stream and status.
// Defining MISR_XMASK_EN adds the xmask field used to block unknown response bits.
interface misr_signature_analyzer_if #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
);
  logic               en;
  logic               start;
  logic [WIDTH-1:0]   poly;
  logic [WIDTH-1:0]   seed;
  logic [WIDTH-1:0]   golden;
  logic [COUNT_W-1:0] num_patterns;
  logic [WIDTH-1:0]   data_in;
  logic               data_valid;
`ifdef MISR_XMASK_EN
  logic [WIDTH-1:0]   xmask;
`endif
  logic [WIDTH-1:0]   signature;
  logic               busy;
  logic               done;
  logic               pass;
  logic [1:0]         fsm_state;

  modport master (
    output en, start, poly, seed, golden, num_patterns, data_in, data_valid,
`ifdef MISR_XMASK_EN
    output xmask,
`endif
    input  signature, busy, done, pass, fsm_state
  );

  modport slave (
    input  en, start, poly, seed, golden, num_patterns, data_in, data_valid,
`ifdef MISR_XMASK_EN
    input  xmask,
`endif
    output signature, busy, done, pass, fsm_state
  );
endinterface

// File: rtl/misr_signature_analyzer.sv
// BIST response compactor: Galois-form MISR with programmable poly/seed, golden compare.
// Optional MISR_XMASK_EN masks response bits (data_in & ~xmask) before compaction.
module misr_signature_analyzer #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
) (
  input  logic                   clock,
  input  logic                   rst,
  misr_signature_analyzer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   sig_q;
  logic [WIDTH-1:0]   poly_l;
  logic [WIDTH-1:0]   golden_l;
  logic [COUNT_W-1:0] num_l;
  logic [COUNT_W-1:0] count;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;

  logic [WIDTH-1:0]   word;
  logic [WIDTH-1:0]   sig_next;
  logic               last_sample;

  // Stream handshake: there is no backpressure. A response word is accepted on
  // every rising edge where en=1, the FSM is in COMPACT and data_valid=1; words
  // offered in any other state or with en=0 are dropped.
  always_comb begin
    word        = '0;
    sig_next    = '0;
    last_sample = 1'b0;
`ifdef MISR_XMASK_EN
    word = bus.data_in & ~bus.xmask;
`else
    word = bus.data_in;
`endif
    sig_next    = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? poly_l : '0) ^ word;
    last_sample = (count == num_l - COUNT_W'(1));
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sig_q    <= '0;
      poly_l   <= '0;
      golden_l <= '0;
      num_l    <= '0;
      count    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else if (bus.en) begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            sig_q    <= bus.seed;
            poly_l   <= bus.poly;
            golden_l <= bus.golden;
            num_l    <= bus.num_patterns;
            count    <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            if (bus.num_patterns == '0) begin
              // Empty session: the seed itself is the signature.
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              pass_q <= (bus.seed == bus.golden);
            end else begin
              state  <= COMPACT;
              busy_q <= 1'b1;
            end
          end
        end
        COMPACT: begin
          if (bus.data_valid) begin
            sig_q <= sig_next;
            count <= count + COUNT_W'(1);
            if (last_sample) begin
              // Verdict uses the signature produced by this same edge.
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              pass_q <= (sig_next == golden_l);
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          pass_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.signature = sig_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_misr_signature_analyzer.sv
// Self-checking bench for misr_signature_analyzer (scoreboarded signatures, directed + random sessions).
module tb_misr_signature_analyzer;

  localparam int WIDTH   = 8;
  localparam int COUNT_W = 8;

  logic clock;
  logic rst;

  misr_signature_analyzer_if #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) bus ();

  misr_signature_analyzer #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] exp_q[$];

  logic [WIDTH-1:0] m_sig;
  logic [WIDTH-1:0] m_poly;
  logic [WIDTH-1:0] m_xmask;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] s,
                                                  input logic [WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0] d,
                                                  input logic [WIDTH-1:0] m);
    logic [WIDTH-1:0] r;
    r = s << 1;
    if (s[WIDTH-1]) r = r ^ p;
    return r ^ (d & ~m);
  endfunction

  // driver tasks
  task automatic start_session(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] s,
                               input logic [WIDTH-1:0] g, input logic [COUNT_W-1:0] n);
    bus.poly = p; bus.seed = s; bus.golden = g; bus.num_patterns = n;
    bus.start = 1'b1;
    m_sig  = s;
    m_poly = p;
    @(posedge clock); #1;
    bus.start = 1'b0;
    // scramble setup inputs: the session must keep the latched copies
    bus.poly = ~p; bus.seed = ~s; bus.golden = ~g; bus.num_patterns = n + 8'd3;
    check("start_sig", bus.signature, s);
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    bus.data_in    = d;
    bus.data_valid = 1'b1;
    m_sig = misr_step(m_sig, m_poly, d, m_xmask);
    exp_q.push_back(m_sig);
    @(posedge clock); #1;
    bus.data_valid = 1'b0;
    if (exp_q.size() == 0) check("sb_empty", 1, 0);
    else check("sig", bus.signature, exp_q.pop_front());
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_status(input string tag, input logic b, input logic d, input logic p);
    check({tag, "_busy"}, bus.busy, b);
    check({tag, "_done"}, bus.done, d);
    check({tag, "_pass"}, bus.pass, p);
  endtask

  logic [WIDTH-1:0] rdata[16];
  logic [WIDTH-1:0] rp, rs, rfinal, rg;
  int rn;

  initial begin
    rst = 1'b0;
    bus.en = 1'b1; bus.start = 1'b0; bus.poly = '0; bus.seed = '0; bus.golden = '0;
    bus.num_patterns = '0; bus.data_in = '0; bus.data_valid = 1'b0;
    m_xmask = '0;
`ifdef MISR_XMASK_EN
    bus.xmask = '0;
`endif
    m_sig = '0; m_poly = '0;
    idle_cycles(2);
    check("rst_sig", bus.signature, 0);
    expect_status("rst", 0, 0, 0);
    check("rst_state", bus.fsm_state, 0);
    rst = 1'b1;
    idle_cycles(1);

    // basic compaction, pass
    start_session(8'h1D, 8'h00, 8'h00, 8'd2);
    expect_status("s1_start", 1, 0, 0);
    send(8'h01);
    check("s1_sig1", bus.signature, 8'h01);
    send(8'h02);
    check("s1_sig2", bus.signature, 8'h00);
    expect_status("s1_end", 0, 1, 1);
    idle_cycles(2);
    expect_status("s1_hold", 0, 1, 1);

    // feedback, pass then fail
    start_session(8'h1D, 8'h80, 8'h1D, 8'd1);
    send(8'h00);
    check("s2_sig", bus.signature, 8'h1D);
    expect_status("s2_end", 0, 1, 1);
    start_session(8'h1D, 8'h80, 8'h1C, 8'd1);
    expect_status("s2b_start", 1, 0, 0);
    send(8'h00);
    expect_status("s2b_end", 0, 1, 0);

    // zero patterns
    bus.poly = 8'h1D; bus.seed = 8'hA5; bus.golden = 8'hA5; bus.num_patterns = 8'd0;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    check("s3_sig", bus.signature, 8'hA5);
    expect_status("s3", 0, 1, 1);
    idle_cycles(1);
    check("s3_busy_later", bus.busy, 0);

    // stall and freeze
    start_session(8'h1D, 8'h00, 8'h00, 8'd2);
    send(8'h01);
    idle_cycles(2);
    check("stall_sig", bus.signature, m_sig);
    bus.en = 1'b0; bus.data_valid = 1'b1; bus.data_in = 8'hFF; bus.start = 1'b1;
    idle_cycles(3);
    check("freeze_sig", bus.signature, m_sig);
    check("freeze_state", bus.fsm_state, 1);
    expect_status("freeze", 1, 0, 0);
    bus.en = 1'b1; bus.data_valid = 1'b0;
    idle_cycles(2);
    bus.start = 1'b0;
    check("ign_start_sig", bus.signature, m_sig);
    expect_status("ign_start", 1, 0, 0);
    send(8'h02);
    check("stall_final", bus.signature, 8'h00);
    expect_status("stall_end", 0, 1, 1);

    // reset mid-run
    start_session(8'h1D, 8'h80, 8'h1D, 8'd3);
    send(8'h37);
    #3 rst = 1'b0;
    #1;
    check("mid_rst_sig", bus.signature, 0);
    expect_status("mid_rst", 0, 0, 0);
    @(posedge clock); #2 rst = 1'b1;
    idle_cycles(1);
    start_session(8'h1D, 8'h80, 8'h1D, 8'd1);
    send(8'h00);
    check("post_rst_sig", bus.signature, 8'h1D);
    expect_status("post_rst", 0, 1, 1);

`ifdef MISR_XMASK_EN
    m_xmask = 8'hFF; bus.xmask = 8'hFF;
    start_session(8'h1D, 8'h80, 8'h1D, 8'd1);
    send(8'h5A);
    check("xmask_sig", bus.signature, 8'h1D);
    expect_status("xmask", 0, 1, 1);
    m_xmask = 8'h0F; bus.xmask = 8'h0F;
`endif

    // random sessions with random valid gaps, golden from the bench model
    for (int k = 0; k < 6; k++) begin
      rp = WIDTH'($urandom_range(1, 255));
      rs = WIDTH'($urandom_range(0, 255));
      rn = $urandom_range(1, 12);
      rfinal = rs;
      for (int i = 0; i < rn; i++) begin
        rdata[i] = WIDTH'($urandom_range(0, 255));
        rfinal = misr_step(rfinal, rp, rdata[i], m_xmask);
      end
      rg = (k % 2 == 0) ? rfinal : (rfinal ^ 8'h01);
      start_session(rp, rs, rg, COUNT_W'(rn));
      for (int i = 0; i < rn; i++) begin
        if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
        send(rdata[i]);
      end
      check("rnd_final", bus.signature, rfinal);
      expect_status("rnd", 0, 1, (k % 2 == 0));
    end

    if (exp_q.size() != 0) check("sb_leftover", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
